// File: rtl/buffer_readout_pkg.sv
// Shared types and widths for the ping-pong buffer readout block.
// The CSUM state exists only when READOUT_CHECKSUM_EN is defined.
package buffer_readout_pkg;

    localparam int ADDR_W        = 12;
    localparam int SAMPLE_W      = 12;
    localparam int DEFAULT_DEPTH = 4096;

`ifdef READOUT_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE,
        CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } state_t;
`endif

endpackage

// File: rtl/buffer_readout.sv
// Reads a filled bank word by word and streams it out over a valid/ready link.
// Define READOUT_CHECKSUM_EN to append an XOR checksum word to every frame.
module buffer_readout
    import buffer_readout_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic                CLK104MHZ,
    input  logic                rst,
    input  logic                bank_full,
    output logic                activeBRAMselect,
    output logic [ADDR_W-1:0]   sampleRequest,
    input  logic [SAMPLE_W-1:0] sendSample,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_done,
    output logic                overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

    state_t                state_reg;
    logic                  bank_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [1:0]            lat_cnt_reg;
    logic [SAMPLE_W-1:0]   data_reg;
    logic                  valid_reg;
    logic                  done_reg;
    logic                  overrun_reg;
`ifdef READOUT_CHECKSUM_EN
    logic [SAMPLE_W-1:0]   csum_reg;
`endif

    always_ff @(posedge CLK104MHZ) begin
        if (rst) begin
            state_reg   <= IDLE;
            bank_reg    <= 1'b0;
            addr_reg    <= '0;
            lat_cnt_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            csum_reg    <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE, DONE: begin
                    if (bank_full) begin
                        bank_reg  <= ~bank_reg;
                        addr_reg  <= '0;
`ifdef READOUT_CHECKSUM_EN
                        csum_reg  <= '0;
`endif
                        state_reg <= ISSUE;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ISSUE: begin
                    lat_cnt_reg <= '0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    // Address is held through WAIT, so the bank output is stable when captured.
                    if (lat_cnt_reg == LAT_LAST) begin
                        data_reg  <= sendSample;
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 2'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_reg <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
                        csum_reg  <= csum_reg ^ data_reg;
`endif
                        if (addr_reg == LAST_ADDR) begin
                            addr_reg  <= '0;
`ifdef READOUT_CHECKSUM_EN
                            state_reg <= CSUM;
`else
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
`endif
                        end else begin
                            addr_reg  <= addr_reg + ADDR_W'(1);
                            state_reg <= ISSUE;
                        end
                    end
                end
`ifdef READOUT_CHECKSUM_EN
                CSUM: begin
                    // First cycle loads the checksum word; later cycles wait for its transfer.
                    if (!valid_reg) begin
                        data_reg  <= csum_reg;
                        valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase

            if (bank_full && state_reg != IDLE && state_reg != DONE) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign activeBRAMselect = bank_reg;
    assign sampleRequest    = addr_reg;
    assign out_data         = data_reg;
    assign out_valid        = valid_reg;
    assign frame_done       = done_reg;
    assign overrun          = overrun_reg;

endmodule

// File: tb/tb_buffer_readout.sv
// Self-checking bench for buffer_readout: frame table, scoreboard of expected words,
// plus hand-written reset and back-to-back sequences.
module tb_buffer_readout;
    import buffer_readout_pkg::*;

    localparam int DEPTH = 8;
`ifdef READOUT_CHECKSUM_EN
    localparam int LAT     = 3;
    localparam bit CSUM_ON = 1'b1;
`else
    localparam int LAT     = 1;
    localparam bit CSUM_ON = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                bank_full;
    logic                activeBRAMselect;
    logic [ADDR_W-1:0]   sampleRequest;
    logic [SAMPLE_W-1:0] sendSample;
    logic [SAMPLE_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                frame_done;
    logic                overrun;

    buffer_readout #(.DEPTH(DEPTH), .RD_LAT(LAT)) dut (
        .CLK104MHZ       (clk),
        .rst             (rst),
        .bank_full       (bank_full),
        .activeBRAMselect(activeBRAMselect),
        .sampleRequest   (sampleRequest),
        .sendSample      (sendSample),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SAMPLE_W-1:0] data;
        bit                  last;
    } exp_t;

    typedef struct {
        int stall_word;
        int stall_len;
        int ovr_word;
        bit started;
        bit chain;
        bit exp_bank;
        bit exp_ovr;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [SAMPLE_W-1:0] sample_fn(input logic [ADDR_W-1:0] a);
`ifdef READOUT_CHECKSUM_EN
        logic [SAMPLE_W-1:0] one;
        one = 12'd1;
        return one << a;
`else
        return a + 12'd100;
`endif
    endfunction

    // Bank model: registered read pipeline of depth LAT.
    logic [SAMPLE_W-1:0] rd_pipe [0:2];
    always @(posedge clk) begin
        rd_pipe[0] <= sample_fn(sampleRequest);
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign sendSample = rd_pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        logic [SAMPLE_W-1:0] x;
        exp_t e;
        x = '0;
        for (int a = 0; a < DEPTH; a++) begin
            e.data = sample_fn(ADDR_W'(a));
            e.last = !CSUM_ON && (a == DEPTH - 1);
            x ^= e.data;
            sb_q.push_back(e);
        end
        if (CSUM_ON) begin
            e.data = x;
            e.last = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    // Output monitor: pops the scoreboard on every transfer, checks frame_done adjacency.
    bit prev_last = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        bit   this_last;
        this_last = 1'b0;
        if (frame_done) check("frame_done_after_last", 32'(prev_last), 32'd1);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got word %0d, expected none", out_data);
            end else begin
                e = sb_q.pop_front();
                check("word", 32'(out_data), 32'(e.data));
                this_last = e.last;
            end
        end
        prev_last = this_last;
    end

    task automatic run_frame(input vec_t v);
        int lat;
        int stalls;
        bit seen_valid;
        bit ovr_sent;
        bit done;
        lat = 1;
        stalls = 0;
        seen_valid = 0;
        ovr_sent = 0;
        done = 0;
        if (!v.started) begin
            push_frame();
            bank_full = 1'b1;
            tick();
            bank_full = 1'b0;
        end
        check("bank_toggle", 32'(activeBRAMselect), 32'(v.exp_bank));
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            if (out_valid && !seen_valid) begin
                seen_valid = 1;
                check("first_word_latency", 32'(lat), 32'(LAT + 2));
            end
            if (!seen_valid) lat++;
            out_ready = 1'b1;
            bank_full = 1'b0;
            if (out_valid && int'(sampleRequest) == v.stall_word && stalls < v.stall_len) begin
                out_ready = 1'b0;
                stalls++;
                check("stall_hold", 32'(out_data), 32'(sample_fn(ADDR_W'(v.stall_word))));
            end
            if (out_valid && int'(sampleRequest) == v.ovr_word && !ovr_sent) begin
                bank_full = 1'b1;
                ovr_sent = 1;
            end
            if (frame_done) begin
                done = 1;
                check("queue_drained", 32'(sb_q.size()), 32'd0);
                check("bank_at_done", 32'(activeBRAMselect), 32'(v.exp_bank));
                check("overrun_at_done", 32'(overrun), 32'(v.exp_ovr));
                if (v.chain) begin
                    push_frame();
                    bank_full = 1'b1;
                end
            end
            tick();
        end
        bank_full = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: got no frame_done, expected one within 500 cycles");
        end
        check("frame_done_width", 32'(frame_done), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bank"},      32'(activeBRAMselect), 32'd0);
        check({tag, "_addr"},      32'(sampleRequest),    32'd0);
        check({tag, "_data"},      32'(out_data),         32'd0);
        check({tag, "_valid"},     32'(out_valid),        32'd0);
        check({tag, "_done"},      32'(frame_done),       32'd0);
        check({tag, "_overrun"},   32'(overrun),          32'd0);
    endtask

    vec_t vecs [0:5];

    initial begin
        int  done_cnt;
        bit  found;

        vecs[0] = '{stall_word: -1, stall_len: 0, ovr_word: -1, started: 0, chain: 0, exp_bank: 1, exp_ovr: 0};
        vecs[1] = '{stall_word:  3, stall_len: 5, ovr_word: -1, started: 0, chain: 0, exp_bank: 0, exp_ovr: 0};
        vecs[2] = '{stall_word: -1, stall_len: 0, ovr_word: -1, started: 0, chain: 1, exp_bank: 1, exp_ovr: 0};
        vecs[3] = '{stall_word: -1, stall_len: 0, ovr_word: -1, started: 1, chain: 0, exp_bank: 0, exp_ovr: 0};
        vecs[4] = '{stall_word: -1, stall_len: 0, ovr_word:  2, started: 0, chain: 0, exp_bank: 1, exp_ovr: 1};
        vecs[5] = '{stall_word: -1, stall_len: 0, ovr_word: -1, started: 0, chain: 0, exp_bank: 0, exp_ovr: 1};

        rst = 1'b1;
        bank_full = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
            if (!vecs[i].chain) repeat (2) tick();
        end

        // Reset in the middle of a frame, while word 4 is being offered.
        push_frame();
        bank_full = 1'b1;
        tick();
        bank_full = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (out_valid && sampleRequest == 12'd4) found = 1;
            else tick();
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL word4_timeout: got no word 4, expected one within 200 cycles");
        end
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check_reset_state("midreset");
        sb_q.delete();
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (frame_done) done_cnt++;
            tick();
        end
        check("no_frame_done_after_reset", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
